// File: rtl/guarded_release_pipe_if.sv
// rtl/guarded_release_pipe_if.sv - data-path signal bundle for guarded_release_pipe
interface guarded_release_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int NCH     = 2,
    parameter int STATE_W = 2
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                    enable;
    logic                    out1_visible;
    logic [NCH*DATA_W-1:0]   secret;
    logic [NCH*DATA_W-1:0]   out1;
    logic [DATA_W-1:0]       out2;
    logic                    out2_valid;
    logic [STATE_W-1:0]      state_o;
    logic [SEL_W-1:0]        sel_o;

    modport master (
        output enable, out1_visible, secret,
        input  out1, out2, out2_valid, state_o, sel_o
    );

    modport slave (
        input  enable, out1_visible, secret,
        output out1, out2, out2_valid, state_o, sel_o
    );
endinterface

// File: rtl/guarded_release_pipe.sv
// rtl/guarded_release_pipe.sv - gated secret path plus registered guard pipeline released on a prev condition
// Optional invariant checker output inv_err is built when INV_CHECK_EN is defined.
module guarded_release_pipe #(
    parameter int DATA_W       = 32,
    parameter int NCH          = 2,
    parameter int STATE_W      = 2,
    parameter int TRIGGER      = 3,
    parameter int RELEASE_PREV = 2,
    parameter int DEPTH        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef INV_CHECK_EN
    output logic                  inv_err,
`endif
    guarded_release_pipe_if.slave bus
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] prev;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_next;
    logic [DATA_W-1:0]  stage [DEPTH];
    logic [DEPTH-1:0]   vld;
    logic [DATA_W-1:0]  chan  [NCH];
    logic               rel;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign chan[c] = bus.secret[c*DATA_W +: DATA_W];
    end

    assign sel_next = (sel == SEL_W'(NCH - 1)) ? '0 : sel + SEL_W'(1);

    // prev starts at all-ones so it always trails state by one
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
            prev  <= '1;
        end else if (bus.enable) begin
            state <= state + STATE_W'(1);
            prev  <= prev + STATE_W'(1);
        end
    end

    // Capture looks at the pre-edge state, independent of enable
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= '0;
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
            if (state == STATE_W'(TRIGGER)) begin
                stage[0] <= chan[sel];
                vld[0]   <= 1'b1;
                sel      <= sel_next;
            end else begin
                stage[0] <= '0;
                vld[0]   <= 1'b0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
                vld[k]   <= vld[k-1];
            end
        end
    end

    assign rel            = (prev == STATE_W'(RELEASE_PREV)) && vld[DEPTH-1];
    assign bus.out2       = rel ? stage[DEPTH-1] + DATA_W'(1) : '0;
    assign bus.out2_valid = rel;
    assign bus.out1       = (bus.enable && bus.out1_visible) ? bus.secret : '0;
    assign bus.state_o    = state;
    assign bus.sel_o      = sel;

`ifdef INV_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_err <= 1'b0;
        end else if (prev != state - STATE_W'(1)) begin
            inv_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_guarded_release_pipe.sv
// tb/tb_guarded_release_pipe.sv - directed self-checking bench for guarded_release_pipe
module tb_guarded_release_pipe;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

`ifdef INV_CHECK_EN
    logic inv_err;
`endif

    guarded_release_pipe_if #(.DATA_W(32), .NCH(2), .STATE_W(2)) bus ();

    guarded_release_pipe #(
        .DATA_W(32), .NCH(2), .STATE_W(2),
        .TRIGGER(3), .RELEASE_PREV(2), .DEPTH(1)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef INV_CHECK_EN
        .inv_err(inv_err),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enable = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.out1_visible = 1'b0;
        bus.secret = {32'hBBBB_BBBB, 32'hAAAA_AAAA};

        // reset then idle
        do_reset();
        repeat (5) step();
        check("idle_state", 64'(bus.state_o), 64'd0);
        check("idle_out2", 64'(bus.out2), 64'd0);
        check("idle_valid", 64'(bus.out2_valid), 64'd0);
        check("idle_sel", 64'(bus.sel_o), 64'd0);

        // out1 gating, combinational only
        bus.enable = 1'b1; bus.out1_visible = 1'b1; #1;
        check("out1_open", bus.out1, 64'hBBBB_BBBB_AAAA_AAAA);
        bus.enable = 1'b0; bus.out1_visible = 1'b1; #1;
        check("out1_en0", bus.out1, 64'd0);
        bus.enable = 1'b1; bus.out1_visible = 1'b0; #1;
        check("out1_vis0", bus.out1, 64'd0);
        bus.enable = 1'b0; #1;

        // blocked release: enable held from reset
        do_reset();
        bus.enable = 1'b1;
        repeat (3) step();
        check("blk_state3", 64'(bus.state_o), 64'd3);
        step();
        check("blk_state0", 64'(bus.state_o), 64'd0);
        check("blk_out2", 64'(bus.out2), 64'd0);
        check("blk_valid", 64'(bus.out2_valid), 64'd0);
        check("blk_sel", 64'(bus.sel_o), 64'd1);

        // reachable release
        do_reset();
        bus.enable = 1'b1;
        repeat (3) step();
        bus.enable = 1'b0;
        bus.secret = {32'hBBBB_BBBB, 32'h0000_0010};
        step();
        check("rel_out2_ch0", 64'(bus.out2), 64'h11);
        check("rel_valid_ch0", 64'(bus.out2_valid), 64'd1);
        check("rel_sel1", 64'(bus.sel_o), 64'd1);
        check("rel_state_held", 64'(bus.state_o), 64'd3);
        step();
        check("rel_out2_ch1", 64'(bus.out2), 64'hBBBB_BBBC);
        check("rel_valid_ch1", 64'(bus.out2_valid), 64'd1);
        check("rel_sel_wrap", 64'(bus.sel_o), 64'd0);
        bus.enable = 1'b1;
        step();
        check("rel_adv_state", 64'(bus.state_o), 64'd0);
        check("rel_adv_valid", 64'(bus.out2_valid), 64'd0);
        check("rel_adv_sel", 64'(bus.sel_o), 64'd1);

        // all-ones wraps to zero, then reset mid-hold flushes
        do_reset();
        bus.enable = 1'b1;
        repeat (3) step();
        bus.enable = 1'b0;
        bus.secret = {32'h1234_5678, 32'hFFFF_FFFF};
        step();
        check("wrap_out2", 64'(bus.out2), 64'd0);
        check("wrap_valid", 64'(bus.out2_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_valid", 64'(bus.out2_valid), 64'd0);
        check("rst_state", 64'(bus.state_o), 64'd0);
        check("rst_out2", 64'(bus.out2), 64'd0);
        check("rst_sel", 64'(bus.sel_o), 64'd0);
        step();
        check("rst_no_release", 64'(bus.out2_valid), 64'd0);

`ifdef INV_CHECK_EN
        do_reset();
        check("inv_reset", 64'(inv_err), 64'd0);
        for (int i = 0; i < 200; i++) begin
            bus.enable = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 15) == 0);
            step();
            check("inv_err", 64'(inv_err), 64'd0);
        end
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
